// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch unit with a small prefetch FIFO between instruction memory
// and the registered Decode-stage outputs; an Execute redirect flushes everything.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PCSrcE,
    input  logic [XLEN-1:0]          PCTargetE,
    input  logic                     StallD,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     imem_waitrequest,
    output logic [XLEN-1:0]          InstrD,
    output logic [XLEN-1:0]          PCD,
    output logic [XLEN-1:0]          PCPlus4D,
    output logic                     ValidD,
    output logic [$clog2(DEPTH):0]   fq_count,
    output logic                     fq_empty,
    output logic                     fq_full
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];

    logic not_full;
    logic accept;
    logic pop;

    assign not_full  = (count < DEPTH_C);
    assign imem_req  = rst & ~PCSrcE & not_full;
    assign accept    = imem_req & ~imem_waitrequest;
    assign pop       = ~PCSrcE & ~StallD & (count != '0);
    assign imem_addr = fetch_pc;

    assign fq_count = count;
    assign fq_empty = (count == '0);
    assign fq_full  = (count == DEPTH_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (PCSrcE) begin
            fetch_pc <= PCTargetE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + PC_STEP;
                tail     <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entries are only ever read while count > 0, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (PCSrcE || (!StallD && !pop)) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (pop) begin
            InstrD   <= q_instr[head];
            PCD      <= q_pc[head];
            PCPlus4D <= q_pc[head] + PC_STEP;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the fetch behaviour.
module tb_fetch_prefetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   PCSrcE = 1'b0;
    logic [XLEN-1:0]        PCTargetE = '0;
    logic                   StallD = 1'b0;
    logic                   imem_req;
    logic [XLEN-1:0]        imem_addr;
    logic [XLEN-1:0]        imem_rdata = '0;
    logic                   imem_waitrequest = 1'b0;
    logic [XLEN-1:0]        InstrD;
    logic [XLEN-1:0]        PCD;
    logic [XLEN-1:0]        PCPlus4D;
    logic                   ValidD;
    logic [$clog2(DEPTH):0] fq_count;
    logic                   fq_empty;
    logic                   fq_full;

    fetch_prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_waitrequest(imem_waitrequest), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .fq_count(fq_count),
        .fq_empty(fq_empty), .fq_full(fq_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_fpc;
    logic [31:0] mq_pc  [$];
    logic [31:0] mq_ins [$];
    logic [31:0] m_instr, m_pc, m_pc4;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_fpc = 32'h0;
        mq_pc.delete();
        mq_ins.delete();
        m_instr = '0; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".InstrD"},   InstrD,   m_instr);
        chk({tag, ".PCD"},      PCD,      m_pc);
        chk({tag, ".PCPlus4D"}, PCPlus4D, m_pc4);
        chk({tag, ".ValidD"},   32'(ValidD), 32'(m_valid));
        chk({tag, ".fq_count"}, 32'(fq_count), 32'(mq_pc.size()));
        chk({tag, ".fq_empty"}, 32'(fq_empty), 32'(mq_pc.size() == 0));
        chk({tag, ".fq_full"},  32'(fq_full),  32'(mq_pc.size() == DEPTH));
    endtask

    // One clock: drive at negedge, check combinational fetch outputs, advance the
    // model, then check registered outputs just after the rising edge.
    task automatic step(input bit pcsrc, input logic [31:0] tgt, input bit stall,
                        input bit wt, input bit rnd_data);
        bit exp_req;
        @(negedge clk);
        PCSrcE           = pcsrc;
        PCTargetE        = tgt;
        StallD           = stall;
        imem_waitrequest = wt;
        imem_rdata       = rnd_data ? $urandom : (m_fpc ^ 32'hA5A5_0000);
        #1;
        exp_req = !pcsrc && (mq_pc.size() < DEPTH);
        chk("imem_req",  32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_fpc);
        if (pcsrc) begin
            mq_pc.delete();
            mq_ins.delete();
            m_fpc = tgt;
            m_instr = '0; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
        end else begin
            if (!stall) begin
                if (mq_pc.size() > 0) begin
                    m_pc    = mq_pc.pop_front();
                    m_instr = mq_ins.pop_front();
                    m_pc4   = m_pc + 32'd4;
                    m_valid = 1'b1;
                end else begin
                    m_instr = '0; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
                end
            end
            if (exp_req && !wt) begin
                mq_pc.push_back(m_fpc);
                mq_ins.push_back(imem_rdata);
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check_state("step");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, ".InstrD"},   InstrD,   32'd0);
        chk({tag, ".PCD"},      PCD,      32'd0);
        chk({tag, ".PCPlus4D"}, PCPlus4D, 32'd0);
        chk({tag, ".ValidD"},   32'(ValidD), 32'd0);
        chk({tag, ".fq_count"}, 32'(fq_count), 32'd0);
        chk({tag, ".imem_addr"}, imem_addr, 32'd0);
    endtask

    initial begin
        logic [31:0] tgt;
        model_reset();
        // reset state
        #2;
        check_zero("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        // straight-line fetch, first valid instruction on the second edge
        step(0, 0, 0, 0, 0);
        chk("first.ValidD", 32'(ValidD), 32'd0);
        step(0, 0, 0, 0, 0);
        chk("first.ValidD1", 32'(ValidD), 32'd1);
        chk("first.PCD", PCD, 32'h0);
        chk("first.PCPlus4D", PCPlus4D, 32'h4);
        chk("first.InstrD", InstrD, 32'hA5A5_0000);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        // stall fills the queue; release drains in PC order
        step(1, 32'h0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        chk("full.fq_full", 32'(fq_full), 32'd1);
        chk("full.imem_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk("drain.PCD", PCD, 32'(i * 4));
        end

        // waitrequest holds the fetch PC
        step(1, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            chk("wait.imem_addr", imem_addr, 32'h8);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        // redirect while stalled with three entries queued
        step(1, 32'h200, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        chk("pre_redir.fq_count", 32'(fq_count), 32'd3);
        step(1, 32'h100, 1, 0, 0);
        chk("redir.fq_count", 32'(fq_count), 32'd0);
        chk("redir.ValidD", 32'(ValidD), 32'd0);
        chk("redir.imem_addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("redir.PCD", PCD, 32'h100);
        chk("redir.ValidD1", 32'(ValidD), 32'd1);

        // simultaneous push and pop, then pointer wrap over 3*DEPTH instructions
        step(1, 32'h0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pushpop.fq_count", 32'(fq_count), 32'd2);
        for (int i = 0; i < 3 * DEPTH + 4; i++) step(0, 0, 0, 0, 1);

        // PC wrap-around modulo 2^32
        step(1, 32'hFFFF_FFF8, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 19) == 0, tgt, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) < 3, 1);
        end

        // short asynchronous reset pulse mid-stream
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);
        #1 rst = 1'b0;
        #1 check_zero("pulse");
        #1 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            step(0, 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the width of the PC and instruction datapath.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded at reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port PCSrcE  input  1  redirect request from Execute.
REQ-007 SHALL have port PCTargetE  input  XLEN  redirect target PC.
REQ-008 SHALL have port StallD  input  1  Decode stall; high holds the D outputs.
REQ-009 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-010 SHALL have port imem_addr  output  XLEN  fetch address; equals the fetch PC.
REQ-011 SHALL have port imem_rdata  input  XLEN  instruction word; valid when imem_req=1 and imem_waitrequest=0.
REQ-012 SHALL have port imem_waitrequest  input  1  memory busy; high means the request is not accepted.
REQ-013 SHALL have ports InstrD, PCD, PCPlus4D  output  XLEN each  registered Decode-stage instruction, PC and PC+4.
REQ-014 SHALL have port ValidD  output  1  D outputs hold a real instruction.
REQ-015 SHALL have port fq_count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-016 SHALL have ports fq_empty, fq_full  output  1 each  occupancy==0 and occupancy==DEPTH.

Function
REQ-017 SHALL drive imem_req = rst & !PCSrcE & (count<DEPTH), combinationally.
REQ-018 SHALL treat a fetch as accepted when imem_req=1 and imem_waitrequest=0 in the same cycle (accept).
REQ-019 SHALL, on accept, push {imem_rdata, fetch PC} at the tail and advance the fetch PC by 4 (mod 2^XLEN).
REQ-020 SHALL hold the fetch PC and push nothing while imem_waitrequest=1.
REQ-021 SHALL pop the head when StallD=0, count>0 and PCSrcE=0, loading InstrD/PCD with the head entry, PCPlus4D with head PC+4, and ValidD=1.
REQ-022 SHALL, when StallD=0 and count==0 and PCSrcE=0, load InstrD=0, PCD=0, PCPlus4D=0 and ValidD=0 (bubble).
REQ-023 SHALL hold all D outputs unchanged when StallD=1 and PCSrcE=0.
REQ-024 SHALL not forward data from memory to D in the same cycle; an instruction accepted at edge N is visible on D at edge N+1 at the earliest.
REQ-025 SHALL leave count unchanged on a simultaneous push and pop; count+1 on push only; count-1 on pop only.
REQ-026 SHALL wrap the head and tail pointers modulo DEPTH.
REQ-027 SHALL not push when full, even if a pop occurs in the same cycle (imem_req is already 0).
REQ-028 SHALL, on PCSrcE=1, at the next edge set fetch PC=PCTargetE, count=0, head=tail=0, and D to a bubble, regardless of StallD.
REQ-029 SHALL, on PCSrcE=1, discard any memory data in that cycle (no request is issued).
REQ-030 SHALL, after a redirect, issue the first request to PCTargetE in the following cycle.

Reset
REQ-031 SHALL, while rst=0, force fetch PC=RESET_PC, count=0, pointers=0, InstrD=PCD=PCPlus4D=0, ValidD=0, imem_req=0, asynchronously.
REQ-032 SHALL abandon any in-flight request when reset asserts mid-operation; the first request after reset release is to RESET_PC.
REQ-033 SHALL leave queue storage contents unreset; storage is unobservable while count==0.

Verification
REQ-034 SHALL pass this test: reset release, waitrequest=0, StallD=0, memory returns PC^32'hA5A5_0000 -> imem_addr is 0,4,8,... on consecutive cycles; the first ValidD=1 is at the second edge, with PCD=0, PCPlus4D=4 and InstrD=32'hA5A5_0000.
REQ-035 SHALL pass this test: StallD=1 held with DEPTH=4 -> fq_full=1 after 4 accepts, imem_req=0, and the D outputs are frozen; releasing StallD pops one entry per cycle in PC order 0,4,8,12.
REQ-036 SHALL pass this test: imem_waitrequest=1 for 3 cycles at PC=8 -> imem_addr holds 8, fq_count does not grow, and PC 8 is pushed exactly once after release.
REQ-037 SHALL pass this test: PCSrcE=1 with PCTargetE=32'h0000_0100 while count=3 and StallD=1 -> at the next edge count=0 and ValidD=0; the next imem_addr is 0x100, and the next valid PCD is 0x100.
REQ-038 SHALL pass this test: push and pop together at count=2 -> count stays 2; wrap-around past entry DEPTH-1 preserves order over 3*DEPTH instructions.
REQ-039 SHALL pass this test: rst pulsed low mid-stream for less than one clock period -> all outputs are 0 immediately and fetch restarts at RESET_PC.
